display_link_framer: RTL

- Parametrised transmit framer for the serial display link. Runs in the link clock domain and feeds the 4-bit-per-clock output serialisers.
- Packs 16-bit pixels, a queued PIO word, and I2C tristate bits into fixed-length frames. Each frame has a sync slot.
- Produces a pulse-width-encoded clock nibble stream alongside the data nibble stream.
- Adds over the previous generation: configurable frame geometry, a multi-entry PIO FIFO with backpressure and overflow flag, link enable with frame-boundary stop and start, and a frame counter.

---
 rtl/display_link_framer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/display_link_framer.sv
// Transmit framer for the serial display link: packs pixels, PIO sideband
// words and I2C tristate bits into fixed frames of 4-clock slots.
//
// Ports:
//   c, rn          link clock, async active-low reset
//   en, active     link enable, framer running
//   pixel_*        pixel offer, registered consume pulse, data, first flag
//   sda_t, scl_t   I2C tristate bits, sampled at frame start
//   wvalid/wready  PIO FIFO write port; wdata word
//   fifo_level     queued PIO words
//   overflow(_clr) sticky dropped-write flag and its clear
//   data_nib       data nibble stream, LSB first
//   clk_nib        pulse-width clock nibble stream, aligned with data_nib
//   frame_start    slot 0 / cyc 0 marker
//   frame_count    frames sent, wrapping
module display_link_framer #(
  parameter int SLOTS      = 25,
  parameter int PIX_SLOTS  = 20,
  parameter int PIO_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        c,
  input  logic                        rn,
  input  logic                        en,
  input  logic                        pixel_valid,
  output logic                        pixel_ready,
  input  logic [15:0]                 pixel_data,
  input  logic                        pixel_first,
  input  logic                        sda_t,
  input  logic                        scl_t,
  input  logic                        wvalid,
  output logic                        wready,
  input  logic [PIO_W-1:0]            wdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic [3:0]                  data_nib,
  output logic [3:0]                  clk_nib,
  output logic                        frame_start,
  output logic [15:0]                 frame_count,
  output logic                        active
);

  localparam int SW  = $clog2(SLOTS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int SBW = PIO_W + 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]    cyc;
  logic [SW-1:0] slot;
  logic          slot_last;
  logic          frame_end;
  logic          fs;
  logic          accept;
  logic          is_sync;

  logic [PIO_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    level;
  logic             push;
  logic             pop;

  logic [SBW-1:0]   sb_reg;
  logic [SBW-1:0]   sb_cur;
  logic [PIO_W-1:0] sb_head;
  logic [SLOTS-1:0] sb_ext;
  logic             sb_bit;

  logic [2:0]  code;
  logic [15:0] clk_word;
  logic [11:0] dsr;
  logic [11:0] csr;
  logic        started;

  // ---------------- run/idle control ----------------
  assign active = (state == RUN);

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Enable is only looked at while idle or on the final clock of a
  // frame, so frames are never truncated.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (en) state_nx = RUN;
      RUN:  if (frame_end && !en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- frame position ----------------
  assign slot_last = (slot == SW'(SLOTS - 1));
  assign frame_end = slot_last && (cyc == 2'd3);
  assign is_sync   = slot_last;
  assign fs        = active && (slot == '0) && (cyc == 2'd0);
  assign frame_start = fs;

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      cyc  <= 2'd0;
      slot <= '0;
    end else if (active) begin
      cyc <= cyc + 2'd1;
      if (cyc == 2'd3) begin
        slot <= slot_last ? '0 : slot + 1'b1;
      end
    end
  end

  assign accept = active && (cyc == 2'd0) &&
                  (slot < SW'(PIX_SLOTS)) && pixel_valid;

  // ---------------- PIO FIFO ----------------
  assign wready     = (level < LW'(FIFO_DEPTH));
  assign fifo_level = level;
  assign push       = wvalid && wready;
  // Pop decision uses the pre-push level: a word written in the
  // frame-start clock waits for the next frame.
  assign pop        = fs && (level != '0);

  always_ff @(posedge c) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      overflow <= 1'b0;
    end else if (wvalid && !wready) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // ---------------- sideband ----------------
  // Slot 0 needs its sideband bit in the capture clock itself, so the
  // freshly assembled vector is used directly during frame start.
  assign sb_head = pop ? mem[rd_ptr] : sb_reg[PIO_W-1:0];
  assign sb_cur  = fs ? {sda_t, scl_t, pop, sb_head} : sb_reg;

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      sb_reg <= '0;
    end else if (fs) begin
      sb_reg <= sb_cur;
    end
  end

  // Slots past the sideband vector read as zero.
  always_comb begin
    sb_ext = '0;
    sb_ext[SBW-1:0] = sb_cur;
  end

  assign sb_bit = sb_ext[slot];
  assign code   = {sb_bit, accept, pixel_first};

  // ---------------- clock pulse-width code ----------------
  always_comb begin
    clk_word = 16'h000F;
    unique case (1'b1)
      is_sync:                         clk_word = 16'h0FFF;
      !is_sync && code[2:1] == 2'b00:  clk_word = 16'h000F;
      !is_sync && code == 3'b010:      clk_word = 16'h001F;
      !is_sync && code == 3'b011:      clk_word = 16'h003F;
      !is_sync && code[2:1] == 2'b10:  clk_word = 16'h007F;
      !is_sync && code == 3'b110:      clk_word = 16'h00FF;
      !is_sync && code == 3'b111:      clk_word = 16'h01FF;
    endcase
  end

  // ---------------- nibble serialisers ----------------
  // Nibble 0 goes straight to the output register at cyc 0; the
  // shifters only hold the three remaining nibbles.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      dsr      <= '0;
      csr      <= '0;
      data_nib <= 4'h0;
      clk_nib  <= 4'h0;
    end else if (!active) begin
      dsr      <= '0;
      csr      <= '0;
      data_nib <= 4'h0;
      clk_nib  <= 4'h0;
    end else if (cyc == 2'd0) begin
      dsr      <= accept ? pixel_data[15:4] : 12'h000;
      data_nib <= accept ? pixel_data[3:0] : 4'h0;
      csr      <= clk_word[15:4];
      clk_nib  <= clk_word[3:0];
    end else begin
      dsr      <= {4'h0, dsr[11:4]};
      data_nib <= dsr[3:0];
      csr      <= {4'h0, csr[11:4]};
      clk_nib  <= csr[3:0];
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      pixel_ready <= 1'b0;
    end else begin
      pixel_ready <= accept;
    end
  end

  // ---------------- frame counter ----------------
  // The first frame after reset is frame zero, so it does not count.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      frame_count <= 16'h0000;
      started     <= 1'b0;
    end else if (fs) begin
      if (started) frame_count <= frame_count + 16'd1;
      started <= 1'b1;
    end
  end

endmodule
